// File: rtl/spad_window_rd.sv
// Windowed read sequencer between the SRAM scratchpad and the PE stream.
// Latency: read issued 1 cycle after start, first word valid 3 cycles after start; 1 word/cycle sustained.
// Backpressure: at most 2 words buffered or in flight; reads stall while out_ready holds the skid buffer full.
//
// Ports: clk/rst (async active-high); start + base_addr/win_len/stride/num_win command;
//        busy/done status; spad_chip_en/spad_ren/spad_raddr/spad_dout scratchpad side;
//        out_data/out_valid/out_ready/out_last stream side.
// Optional feature macro: SPAD_WIN_ZERO_PAD_EN -- addresses past the end of the scratchpad
// read as zero (no SRAM access) instead of wrapping.
module spad_window_rd #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   win_len,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [CNT_WIDTH-1:0]  num_win,
  output logic                  busy,
  output logic                  done,
  output logic                  spad_chip_en,
  output logic                  spad_ren,
  output logic [ADDR_WIDTH-1:0] spad_raddr,
  input  logic [DATA_WIDTH-1:0] spad_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  localparam logic [ADDR_WIDTH:0]  LEN_MAX = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]  LEN_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   win_len_q, win_len_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  num_win_q, num_win_d;
  logic [ADDR_WIDTH-1:0] win_start_q, win_start_d;
  logic [ADDR_WIDTH:0]   offset_q, offset_d;
  logic [CNT_WIDTH-1:0]  win_cnt_q, win_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  infl_last_q, infl_last_d;
  logic [DATA_WIDTH-1:0] buf_dat_q [2];
  logic [DATA_WIDTH-1:0] buf_dat_d [2];
  logic [1:0]            buf_last_q, buf_last_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  pop, credit, issue, win_last, cmd_last, slot_pad;
  logic [1:0]            pending;
  logic [DATA_WIDTH-1:0] push_dat;

`ifdef SPAD_WIN_ZERO_PAD_EN
  logic                  infl_pad_q, infl_pad_d;
  logic [ADDR_WIDTH:0]   unwrapped;
  assign unwrapped  = {1'b0, win_start_q} + offset_q;
  assign slot_pad   = (unwrapped >= LEN_MAX);
  assign spad_raddr = unwrapped[ADDR_WIDTH-1:0];
  assign push_dat   = infl_pad_q ? '0 : spad_dout;
`else
  assign slot_pad   = 1'b0;
  assign spad_raddr = win_start_q + offset_q[ADDR_WIDTH-1:0];
  assign push_dat   = spad_dout;
`endif

  assign pop      = (occ_q != 2'd0) && out_ready;
  assign pending  = occ_q + {1'b0, inflight_q};
  // A slot may be issued only if it is guaranteed a buffer entry on return.
  assign credit   = (pending < 2'd2) || ((pending == 2'd2) && pop);
  assign issue    = (state_q == ISSUE) && credit;
  assign win_last = (offset_q == win_len_q - LEN_ONE);
  assign cmd_last = (win_cnt_q == num_win_q - CNT_ONE);

  assign spad_ren     = issue && !slot_pad;
  assign spad_chip_en = issue && !slot_pad;
  assign out_valid    = (occ_q != 2'd0);
  assign out_data     = buf_dat_q[rd_ptr_q];
  assign out_last     = buf_last_q[rd_ptr_q] && out_valid;
  assign busy         = busy_q;
  assign done         = done_q;

  always_comb begin
    state_d     = state_q;
    win_len_d   = win_len_q;
    stride_d    = stride_q;
    num_win_d   = num_win_q;
    win_start_d = win_start_q;
    offset_d    = offset_q;
    win_cnt_d   = win_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          win_len_d   = (win_len > LEN_MAX) ? LEN_MAX : win_len;
          stride_d    = stride;
          num_win_d   = num_win;
          win_start_d = base_addr;
          offset_d    = '0;
          win_cnt_d   = '0;
          state_d     = ((win_len != '0) && (num_win != '0)) ? ISSUE : FIN;
        end
      end
      ISSUE: begin
        if (issue) begin
          if (win_last) begin
            offset_d    = '0;
            win_start_d = win_start_q + stride_q;
            win_cnt_d   = win_cnt_q + CNT_ONE;
            if (cmd_last) state_d = DRAIN;
          end else begin
            offset_d = offset_q + LEN_ONE;
          end
        end
      end
      DRAIN:   if ((occ_q == 2'd0) && !inflight_q) state_d = FIN;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // Return path: the scratchpad word lands one cycle after issue, with its last flag.
  always_comb begin
    inflight_d  = issue;
    infl_last_d = issue && win_last;
`ifdef SPAD_WIN_ZERO_PAD_EN
    infl_pad_d  = issue && slot_pad;
`endif
    buf_dat_d   = buf_dat_q;
    buf_last_d  = buf_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    if (inflight_q) begin
      buf_dat_d[wr_ptr_q]  = push_dat;
      buf_last_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({inflight_q, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_len_q   <= '0;
      stride_q    <= '0;
      num_win_q   <= '0;
      win_start_q <= '0;
      offset_q    <= '0;
      win_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
`ifdef SPAD_WIN_ZERO_PAD_EN
      infl_pad_q  <= 1'b0;
`endif
      buf_dat_q[0] <= '0;
      buf_dat_q[1] <= '0;
      buf_last_q  <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_len_q   <= win_len_d;
      stride_q    <= stride_d;
      num_win_q   <= num_win_d;
      win_start_q <= win_start_d;
      offset_q    <= offset_d;
      win_cnt_q   <= win_cnt_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
`ifdef SPAD_WIN_ZERO_PAD_EN
      infl_pad_q  <= infl_pad_d;
`endif
      buf_dat_q   <= buf_dat_d;
      buf_last_q  <= buf_last_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_spad_window_rd.sv
module tb_spad_window_rd;
  localparam int DW = 8, DEPTH = 16, AW = 4, CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   win_len = '0;
  logic [AW-1:0] stride = '0;
  logic [CW-1:0] num_win = '0;
  logic          busy, done, spad_chip_en, spad_ren;
  logic [AW-1:0] spad_raddr;
  logic [DW-1:0] spad_dout = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last;
  logic          out_ready = 1'b1;

  spad_window_rd #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .win_len(win_len),
    .stride(stride), .num_win(num_win), .busy(busy), .done(done),
    .spad_chip_en(spad_chip_en), .spad_ren(spad_ren), .spad_raddr(spad_raddr),
    .spad_dout(spad_dout), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Scratchpad model: registered output, one-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 'h10);
  always @(posedge clk) if (spad_chip_en && spad_ren) spad_dout <= mem[spad_raddr];

  int n_checks = 0, n_fail = 0;
  logic [8:0] exp_q [$];
  int ncyc = 0, ren_cnt = 0, done_cnt = 0, hs_cnt = 0;
  int fv = -1, first_hs = 0, last_hs = 0, done_neg = -1, start_neg = 0;
  int exp_ren = 0, exp_words = 0;
  bit stall_prev = 0;
  logic [DW-1:0] held_data;
  logic held_last;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Output monitor: samples on the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    logic [8:0] e;
    ncyc++;
    if (!rst) begin
      if (spad_ren) ren_cnt++;
      if (done) begin done_cnt++; done_neg = ncyc; end
      if (out_valid && fv < 0) fv = ncyc;
      if (stall_prev) begin
        check_val("hold_valid", 32'(out_valid), 32'd1);
        check_val("hold_data", 32'(out_data), 32'(held_data));
        check_val("hold_last", 32'(out_last), 32'(held_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_val("extra_word", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check_val("data", 32'(out_data), 32'(e[7:0]));
          check_val("last", 32'(out_last), 32'(e[8]));
        end
        if (hs_cnt == 0) first_hs = ncyc;
        last_hs = ncyc;
        hs_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic start_cmd(input int b, input int l, input int s, input int n, input bit second);
    int ws, ua;
    bit pad;
    exp_ren = 0; exp_words = 0;
    for (int w = 0; w < n; w++) begin
      ws = (b + w * s) % DEPTH;
      for (int o = 0; o < l; o++) begin
        ua = ws + o;
`ifdef SPAD_WIN_ZERO_PAD_EN
        pad = (ua >= DEPTH);
`else
        pad = 1'b0;
`endif
        if (!pad) exp_ren++;
        exp_words++;
        exp_q.push_back({(o == l - 1), (pad ? 8'h00 : 8'(ua % DEPTH + 'h10))});
      end
    end
    @(posedge clk); #1;
    ren_cnt = 0; done_cnt = 0; hs_cnt = 0; fv = -1; done_neg = -1;
    out_ready = 1'b1;
    base_addr = AW'(b); win_len = (AW+1)'(l); stride = AW'(s); num_win = CW'(n);
    start = 1'b1;
    start_neg = ncyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    if (second) begin
      // Must be ignored: the block is busy with the command above.
      base_addr = 4'd9; win_len = 5'd1; stride = 4'd3; num_win = 8'd5;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_finish(input bit toggle, input string tag);
    logic [5:0] pat;
    bit fin;
    int k;
    pat = 6'b101001;
    fin = 0; k = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      out_ready = toggle ? pat[k % 6] : 1'b1;
      k++;
      if (done_cnt != 0) begin fin = 1; break; end
    end
    check_val({tag, "_finished"}, 32'(fin), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check_val({tag, "_ren_cnt"}, 32'(ren_cnt), 32'(exp_ren));
    check_val({tag, "_words"}, 32'(hs_cnt), 32'(exp_words));
    check_val({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
    if (exp_words != 0) begin
      check_val({tag, "_latency"}, 32'(fv - start_neg), 32'd3);
      if (!toggle) check_val({tag, "_rate"}, 32'(last_hs - first_hs), 32'(exp_words - 1));
    end
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_ren"}, 32'(spad_ren), 32'd0);
    check_val({tag, "_chip_en"}, 32'(spad_chip_en), 32'd0);
    check_val({tag, "_raddr"}, 32'(spad_raddr), 32'd0);
    check_val({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_data"}, 32'(out_data), 32'd0);
    check_val({tag, "_last"}, 32'(out_last), 32'd0);
  endtask

  initial begin
    bit got2;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Two overlapping windows, full rate, with an ignored second start.
    start_cmd(2, 3, 1, 2, 1'b1);
    wait_finish(1'b0, "basic");

    // Single window crossing the end of the scratchpad.
    start_cmd(14, 4, 0, 1, 1'b0);
    wait_finish(1'b0, "wrap");

    // Same as the first case under consumer backpressure.
    start_cmd(2, 3, 1, 2, 1'b0);
    wait_finish(1'b1, "stall");

    // Empty command: straight to done, second start during it ignored.
    start_cmd(5, 3, 1, 0, 1'b1);
    check_val("zero_done_cycle", 32'(done_neg - start_neg), 32'd1);
    wait_finish(1'b0, "zero");

    start_cmd(5, 0, 1, 3, 1'b0);
    wait_finish(1'b0, "zlen");

    // Reset in the middle of a command, then a fresh run.
    start_cmd(2, 3, 1, 2, 1'b0);
    got2 = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (hs_cnt >= 2) begin got2 = 1; break; end
    end
    check_val("abort_two_words", 32'(got2), 32'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("abort");
    check_val("abort_no_done", 32'(done_cnt), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_val("abort_no_done_held", 32'(done_cnt), 32'd0);
    rst = 1'b0;
    start_cmd(2, 3, 1, 2, 1'b0);
    wait_finish(1'b0, "fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
